// File: rtl/load_store_wb.sv
// -----------------------------------------------------------------------------
// load_store_wb -- memory / writeback stage feeding the register file.
//
// Accepts one instruction at a time from execute (load, store or ALU result
// pass-through). Runs the data-memory req/gnt/rvalid handshake, aligns and
// extends load data, builds store strobes and replicated store data, and is
// the only driver of the register-file write port. Misaligned accesses,
// illegal funct3 and memory timeouts end in a one-cycle fault pulse.
//
// Ports
//   clk, rst        clock; synchronous active-low reset
//   in_valid/ready  execute handshake; ready only in IDLE
//   in_is_load      load op
//   in_is_store     store op (neither set = ALU pass-through)
//   in_funct3       RV32I funct3
//   in_addr         effective address, or ALU result for pass-through
//   in_wdata        store data (rs2)
//   in_rd           destination register index
//   mem_req/we      memory request / write flag
//   mem_addr        word-aligned address
//   mem_wdata/wstrb replicated store data / byte strobes (0 for loads)
//   mem_gnt         request accepted
//   mem_rvalid      response valid (loads and stores)
//   mem_rdata       load word
//   wb_we/rd/data   register-file write port, held for one full cycle
//   fault           one-cycle fault pulse
//   fault_cause     1 misaligned, 2 timeout, 3 illegal funct3
//   fault_addr      in_addr of the faulting op
// -----------------------------------------------------------------------------
module load_store_wb #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_is_load,
   input  logic        in_is_store,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_addr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RESP,
      S_WB,
      S_FAULT
   } state_e;

   localparam logic [1:0] CAUSE_MISALIGNED = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT    = 2'd2;
   localparam logic [1:0] CAUSE_ILLEGAL    = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e            state_q,       state_d;
   logic              is_load_q,     is_load_d;
   logic              is_store_q,    is_store_d;
   logic [2:0]        funct3_q,      funct3_d;
   logic [31:0]       addr_q,        addr_d;
   logic [31:0]       wdata_q,       wdata_d;
   logic [4:0]        rd_q,          rd_d;
   logic [CNT_W-1:0]  cnt_q,         cnt_d;
   logic              wb_we_q,       wb_we_d;
   logic [4:0]        wb_rd_q,       wb_rd_d;
   logic [31:0]       wb_data_q,     wb_data_d;
   logic              fault_q,       fault_d;
   logic [1:0]        fault_cause_q, fault_cause_d;
   logic [31:0]       fault_addr_q,  fault_addr_d;

   // funct3 legality: loads allow B/H/W/BU/HU, stores only B/H/W.
   function automatic logic f3_illegal(input logic ld, input logic [2:0] f3);
      if (ld) return !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      else    return !(f3 inside {3'b000, 3'b001, 3'b010});
   endfunction

   // funct3[1:0] encodes access size for both loads and stores.
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b01:   return a[0];
         2'b10:   return |a;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] load_align(input logic [2:0]  f3,
                                              input logic [1:0]  a,
                                              input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[{a, 3'b000} +: 8];
      h = d[{a[1], 4'b0000} +: 16];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return d;
      endcase
   endfunction

   // NOTE: state registers use non-blocking assignments and a synchronous
   // reset; every register, including the latched op fields, is cleared so
   // outputs derived from them come out of reset at 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         is_load_q     <= 1'b0;
         is_store_q    <= 1'b0;
         funct3_q      <= 3'd0;
         addr_q        <= 32'd0;
         wdata_q       <= 32'd0;
         rd_q          <= 5'd0;
         cnt_q         <= '0;
         wb_we_q       <= 1'b0;
         wb_rd_q       <= 5'd0;
         wb_data_q     <= 32'd0;
         fault_q       <= 1'b0;
         fault_cause_q <= 2'd0;
         fault_addr_q  <= 32'd0;
      end else begin
         state_q       <= state_d;
         is_load_q     <= is_load_d;
         is_store_q    <= is_store_d;
         funct3_q      <= funct3_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rd_q          <= rd_d;
         cnt_q         <= cnt_d;
         wb_we_q       <= wb_we_d;
         wb_rd_q       <= wb_rd_d;
         wb_data_q     <= wb_data_d;
         fault_q       <= fault_d;
         fault_cause_q <= fault_cause_d;
         fault_addr_q  <= fault_addr_d;
      end
   end

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path through
      // the case statement can infer a latch; pulses default to 0.
      state_d       = state_q;
      is_load_d     = is_load_q;
      is_store_d    = is_store_q;
      funct3_d      = funct3_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rd_d          = rd_q;
      cnt_d         = cnt_q;
      wb_we_d       = 1'b0;
      wb_rd_d       = wb_rd_q;
      wb_data_d     = wb_data_q;
      fault_d       = 1'b0;
      fault_cause_d = fault_cause_q;
      fault_addr_d  = fault_addr_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               is_load_d  = in_is_load;
               // A malformed op flagged as both is treated as a load.
               is_store_d = in_is_store && !in_is_load;
               funct3_d   = in_funct3;
               addr_d     = in_addr;
               wdata_d    = in_wdata;
               rd_d       = in_rd;
               cnt_d      = '0;
               if (!in_is_load && !in_is_store) begin
                  state_d   = S_WB;
                  wb_we_d   = (in_rd != 5'd0);
                  wb_rd_d   = in_rd;
                  wb_data_d = in_addr;
               end else if (f3_illegal(in_is_load, in_funct3)) begin
                  state_d       = S_FAULT;
                  fault_d       = 1'b1;
                  fault_cause_d = CAUSE_ILLEGAL;
                  fault_addr_d  = in_addr;
               end else if (misaligned(in_funct3, in_addr[1:0])) begin
                  state_d       = S_FAULT;
                  fault_d       = 1'b1;
                  fault_cause_d = CAUSE_MISALIGNED;
                  fault_addr_d  = in_addr;
               end else begin
                  state_d = S_REQ;
               end
            end
         end

         S_REQ, S_RESP: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A response completes the op even if it arrives with the grant.
            if (mem_rvalid && (state_q == S_RESP || mem_gnt)) begin
               if (is_load_q) begin
                  state_d   = S_WB;
                  wb_we_d   = (rd_q != 5'd0);
                  wb_rd_d   = rd_q;
                  wb_data_d = load_align(funct3_q, addr_q[1:0], mem_rdata);
               end else begin
                  state_d = S_IDLE;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d       = S_FAULT;
               fault_d       = 1'b1;
               fault_cause_d = CAUSE_TIMEOUT;
               fault_addr_d  = addr_q;
            end else if (state_q == S_REQ && mem_gnt) begin
               state_d = S_RESP;
            end
         end

         S_WB:    state_d = S_IDLE;
         S_FAULT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready = (state_q == S_IDLE);
   assign mem_req  = (state_q == S_REQ);
   assign mem_we   = is_store_q;
   assign mem_addr = {addr_q[31:2], 2'b00};

   always_comb begin
      case (funct3_q[1:0])
         2'b00:   mem_wdata = {4{wdata_q[7:0]}};
         2'b01:   mem_wdata = {2{wdata_q[15:0]}};
         default: mem_wdata = wdata_q;
      endcase
   end

   always_comb begin
      mem_wstrb = 4'b0000;
      if (is_store_q) begin
         case (funct3_q[1:0])
            2'b00:   mem_wstrb = 4'b0001 << addr_q[1:0];
            2'b01:   mem_wstrb = 4'b0011 << addr_q[1:0];
            default: mem_wstrb = 4'b1111;
         endcase
      end
   end

   assign wb_we       = wb_we_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign fault       = fault_q;
   assign fault_cause = fault_cause_q;
   assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_load_store_wb.sv
// -----------------------------------------------------------------------------
// tb_load_store_wb -- directed self-checking bench for load_store_wb.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_load_store_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_is_load;
   logic        in_is_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr;
   logic [31:0] in_wdata;
   logic [4:0]  in_rd;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        fault;
   logic [1:0]  fault_cause;
   logic [31:0] fault_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   load_store_wb #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_is_load  (in_is_load),
      .in_is_store (in_is_store),
      .in_funct3   (in_funct3),
      .in_addr     (in_addr),
      .in_wdata    (in_wdata),
      .in_rd       (in_rd),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .fault       (fault),
      .fault_cause (fault_cause),
      .fault_addr  (fault_addr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Presents one op for a single cycle; returns in the first post-accept state.
   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd);
      in_valid    = 1'b1;
      in_is_load  = ld;
      in_is_store = st;
      in_funct3   = f3;
      in_addr     = addr;
      in_wdata    = wd;
      in_rd       = rd;
      tick();
      in_valid    = 1'b0;
      in_is_load  = 1'b0;
      in_is_store = 1'b0;
      in_funct3   = 3'd0;
      in_addr     = 32'd0;
      in_wdata    = 32'd0;
      in_rd       = 5'd0;
   endtask

   // One memory op with a given number of grant wait cycles; 'combined'
   // returns rvalid together with gnt.
   task automatic mem_txn(input string tag, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int wait_gnt,
                          input logic combined, input logic [31:0] exp_maddr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                          input logic exp_wbwe, input logic [31:0] exp_wb);
      issue(ld, st, f3, addr, wd, rd);
      check({tag, " req"}, mem_req, 1'b1);
      check({tag, " in_ready busy"}, in_ready, 1'b0);
      for (int i = 0; i < wait_gnt; i++) tick();
      check({tag, " req held"}, mem_req, 1'b1);
      check({tag, " mem_addr"}, mem_addr, exp_maddr);
      check({tag, " mem_we"}, mem_we, st);
      check({tag, " wstrb"}, mem_wstrb, exp_strb);
      if (st) check({tag, " mem_wdata"}, mem_wdata, exp_wdata);
      mem_gnt = 1'b1;
      if (combined) begin
         mem_rvalid = 1'b1;
         mem_rdata  = rdata;
      end
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!combined) begin
         check({tag, " req drop"}, mem_req, 1'b0);
         mem_rvalid = 1'b1;
         mem_rdata  = rdata;
         tick();
         mem_rvalid = 1'b0;
      end
      check({tag, " wb_we"}, wb_we, exp_wbwe);
      if (exp_wbwe) begin
         check({tag, " wb_rd"}, wb_rd, rd);
         check({tag, " wb_data"}, wb_data, exp_wb);
      end
      tick();
      check({tag, " wb_we after"}, wb_we, 1'b0);
      check({tag, " ready after"}, in_ready, 1'b1);
   endtask

   task automatic fault_op(input string tag, input logic ld, input logic st,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [1:0] exp_cause);
      issue(ld, st, f3, addr, 32'h5555_AAAA, 5'd9);
      check({tag, " fault"}, fault, 1'b1);
      check({tag, " cause"}, fault_cause, exp_cause);
      check({tag, " fault_addr"}, fault_addr, addr);
      check({tag, " no req"}, mem_req, 1'b0);
      check({tag, " no wb"}, wb_we, 1'b0);
      tick();
      check({tag, " fault drop"}, fault, 1'b0);
      check({tag, " no req after"}, mem_req, 1'b0);
      check({tag, " ready"}, in_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_req;
      rst         = 1'b0;
      in_valid    = 1'b0;
      in_is_load  = 1'b0;
      in_is_store = 1'b0;
      in_funct3   = 3'd0;
      in_addr     = 32'd0;
      in_wdata    = 32'd0;
      in_rd       = 5'd0;
      mem_gnt     = 1'b0;
      mem_rvalid  = 1'b0;
      mem_rdata   = 32'd0;
      tick();
      tick();
      check("reset in_ready", in_ready, 1'b1);
      check("reset mem_req", mem_req, 1'b0);
      check("reset mem_we", mem_we, 1'b0);
      check("reset mem_addr", mem_addr, 32'd0);
      check("reset wstrb", mem_wstrb, 4'd0);
      check("reset wb_we", wb_we, 1'b0);
      check("reset wb_data", wb_data, 32'd0);
      check("reset fault", fault, 1'b0);
      check("reset fault_addr", fault_addr, 32'd0);
      rst = 1'b1;
      tick();

      // Loads
      mem_txn("LB",  1, 0, 3'b000, 32'h103, 0, 5'd5, 32'h80FF_FF7F, 1, 0,
              32'h100, 4'b0000, 0, 1, 32'hFFFF_FF80);
      mem_txn("LHU", 1, 0, 3'b101, 32'h102, 0, 5'd6, 32'hBEEF_1234, 0, 0,
              32'h100, 4'b0000, 0, 1, 32'h0000_BEEF);
      mem_txn("LH",  1, 0, 3'b001, 32'h102, 0, 5'd6, 32'hBEEF_1234, 0, 1,
              32'h100, 4'b0000, 0, 1, 32'hFFFF_BEEF);
      mem_txn("LBU", 1, 0, 3'b100, 32'h101, 0, 5'd7, 32'h1234_5678, 2, 0,
              32'h100, 4'b0000, 0, 1, 32'h0000_0056);
      mem_txn("LW",  1, 0, 3'b010, 32'h104, 0, 5'd31, 32'hDEAD_BEEF, 0, 0,
              32'h104, 4'b0000, 0, 1, 32'hDEAD_BEEF);
      mem_txn("LW rd0", 1, 0, 3'b010, 32'h108, 0, 5'd0, 32'h1111_2222, 0, 0,
              32'h108, 4'b0000, 0, 0, 32'd0);

      // Stores
      mem_txn("SB", 0, 1, 3'b000, 32'h201, 32'h1234_5678, 5'd3, 32'd0, 0, 0,
              32'h200, 4'b0010, 32'h7878_7878, 0, 32'd0);
      mem_txn("SH", 0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd3, 32'd0, 1, 1,
              32'h200, 4'b1100, 32'hABCD_ABCD, 0, 32'd0);
      mem_txn("SW", 0, 1, 3'b010, 32'h300, 32'hCAFE_F00D, 5'd3, 32'd0, 0, 0,
              32'h300, 4'b1111, 32'hCAFE_F00D, 0, 32'd0);

      // Faults without memory access
      fault_op("LW misaligned",  1, 0, 3'b010, 32'h102, 2'd1);
      fault_op("LH misaligned",  1, 0, 3'b001, 32'h101, 2'd1);
      fault_op("SH misaligned",  0, 1, 3'b001, 32'h203, 2'd1);
      fault_op("load f3 011",    1, 0, 3'b011, 32'h100, 2'd3);
      fault_op("store f3 100",   0, 1, 3'b100, 32'h100, 2'd3);

      // ALU pass-through
      issue(0, 0, 3'b000, 32'hDEAD_0001, 0, 5'd7);
      check("ALU wb_we", wb_we, 1'b1);
      check("ALU wb_rd", wb_rd, 5'd7);
      check("ALU wb_data", wb_data, 32'hDEAD_0001);
      check("ALU no req", mem_req, 1'b0);
      check("ALU in_ready busy", in_ready, 1'b0);
      tick();
      check("ALU wb_we drop", wb_we, 1'b0);
      check("ALU ready", in_ready, 1'b1);
      issue(0, 0, 3'b000, 32'h0000_0042, 0, 5'd0);
      check("ALU rd0 wb_we", wb_we, 1'b0);
      check("ALU rd0 in WB", in_ready, 1'b0);
      tick();
      check("ALU rd0 wb_we after", wb_we, 1'b0);
      check("ALU rd0 ready", in_ready, 1'b1);

      // Timeout with gnt held low
      issue(1, 0, 3'b010, 32'h400, 0, 5'd4);
      n_req = 0;
      for (int i = 0; i < 40; i++) begin
         if (!mem_req) break;
         n_req++;
         tick();
      end
      check("timeout req cycles", n_req, 16);
      check("timeout fault", fault, 1'b1);
      check("timeout cause", fault_cause, 2'd2);
      check("timeout fault_addr", fault_addr, 32'h400);
      check("timeout no wb", wb_we, 1'b0);
      tick();
      check("timeout fault drop", fault, 1'b0);
      check("timeout ready", in_ready, 1'b1);

      // Reset during REQ
      issue(1, 0, 3'b010, 32'h500, 0, 5'd8);
      check("rst REQ req", mem_req, 1'b1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("rst REQ req drop", mem_req, 1'b0);
      check("rst REQ ready", in_ready, 1'b1);

      // Reset during RESP, then a late rvalid
      issue(1, 0, 3'b010, 32'h600, 0, 5'd8);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      check("rst RESP in RESP", in_ready, 1'b0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("rst RESP req", mem_req, 1'b0);
      check("rst RESP ready", in_ready, 1'b1);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h7777_7777;
      tick();
      mem_rvalid = 1'b0;
      check("late rvalid no wb", wb_we, 1'b0);
      tick();
      check("late rvalid no wb 2", wb_we, 1'b0);
      check("late rvalid ready", in_ready, 1'b1);

      // Back-to-back ALU op still works after the aborted load
      issue(0, 0, 3'b000, 32'h0BAD_F00D, 0, 5'd1);
      check("ALU after rst wb_data", wb_data, 32'h0BAD_F00D);
      check("ALU after rst wb_we", wb_we, 1'b1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
